// File: rtl/tff_counter_ctrl_pkg.sv
// Shared types for the T-FF bank counter controller and its next-count helper.
package tff_counter_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/tff_next_calc.sv
// Modulo-M up/down next-count and wrap detection; mod_n==0 selects M = 2**WIDTH.
module tff_next_calc #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] mod_n,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_cond
);

    localparam int unsigned MW = WIDTH + 1;

    logic [MW-1:0] m;
    logic [MW-1:0] m_last;
    logic [MW-1:0] q_ext;

    // Extra bit lets M reach 2**WIDTH; q >= M covers a modulus lowered mid-count.
    always_comb begin
        q_ext     = {1'b0, q};
        m         = (mod_n == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mod_n};
        m_last    = m - MW'(1);
        nxt       = '0;
        wrap_cond = 1'b0;
        if (up_dn) begin
            if (q_ext >= m_last) begin
                nxt       = '0;
                wrap_cond = 1'b1;
            end else begin
                nxt = q + WIDTH'(1);
            end
        end else begin
            if ((q == '0) || (q_ext >= m)) begin
                nxt       = m_last[WIDTH-1:0];
                wrap_cond = 1'b1;
            end else begin
                nxt = q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequences an external T-FF bank as a modulo-N up/down counter, clears it after
// reset and flags any bit that fails to follow its commanded toggle.
module tff_counter_ctrl
    import tff_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] mod_n,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             wrap,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] nxt;
    logic             wrap_cond;
    logic [WIDTH-1:0] exp;
    logic             chk;

    tff_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .q         (q),
        .mod_n     (mod_n),
        .up_dn     (up_dn),
        .nxt       (nxt),
        .wrap_cond (wrap_cond)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and toggle decode; clr outranks stop, which outranks start.
    always_comb begin
        state_nxt = state;
        t         = '0;
        case (state)
            ST_CLEAR: begin
                t = q;
                if (!clr && (q == '0)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (clr)        state_nxt = ST_CLEAR;
                else if (stop)  state_nxt = ST_IDLE;
                else if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                t = q ^ nxt;
                if (clr)       state_nxt = ST_CLEAR;
                else if (stop) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clr)        state_nxt = ST_CLEAR;
                else if (stop)  state_nxt = ST_PAUSE;
                else if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy = (state == ST_RUN);

    // exp is the value the bank must show next cycle; chk marks it as binding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp  <= '0;
            chk  <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            exp  <= (state == ST_RUN) ? nxt : q;
            chk  <= (state == ST_RUN) && !clr && !stop;
            wrap <= (state == ST_RUN) && wrap_cond;
            if (state == ST_CLEAR) begin
                err <= 1'b0;
            end else if (chk && (q != exp)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
